// File: rtl/mole_timer_bank_if.sv
// Bundle of control inputs and status outputs exchanged between the game core
// and the mole timer bank. The game core drives through the master modport and
// the timer bank answers through the slave modport.
interface mole_timer_bank_if #(
   parameter int NUM_HOLES = 4,
   parameter int MISS_W    = 8
);
   logic                 enable;
   logic                 pause;
   logic                 clear_stats;
   logic [1:0]           level;
   logic [NUM_HOLES-1:0] start;
   logic [NUM_HOLES-1:0] hit;
   logic [NUM_HOLES-1:0] active;
   logic [NUM_HOLES-1:0] timeout_pulse;
   logic [NUM_HOLES-1:0] hit_pulse;
   logic                 any_active;
   logic [MISS_W-1:0]    miss_count;

   modport master (
      output enable,
      output pause,
      output clear_stats,
      output level,
      output start,
      output hit,
      input  active,
      input  timeout_pulse,
      input  hit_pulse,
      input  any_active,
      input  miss_count
   );

   modport slave (
      input  enable,
      input  pause,
      input  clear_stats,
      input  level,
      input  start,
      input  hit,
      output active,
      output timeout_pulse,
      output hit_pulse,
      output any_active,
      output miss_count
   );
endinterface

// File: rtl/mole_timer_bank.sv
// Bank of independent mole lifetime timers. Each hole counts down a lifetime
// picked from four difficulty levels when its mole appears, and ends with
// either a hit pulse (valid whack) or a timeout pulse (mole escaped). Escapes
// are totalled in a saturating miss counter for the scoring/lives logic.
module mole_timer_bank #(
   parameter int NUM_HOLES = 4,
   parameter int CNT_W     = 8,
   parameter int MISS_W    = 8,
   parameter int TICKS_L0  = 10,
   parameter int TICKS_L1  = 7,
   parameter int TICKS_L2  = 4,
   parameter int TICKS_L3  = 2
) (
   input  logic               clk_game,
   input  logic               rst,
   mole_timer_bank_if.slave   bus
);

   // Wide enough to add a full popcount to the miss total without wrapping.
   localparam int SUM_W = MISS_W + $clog2(NUM_HOLES + 1);
   localparam logic [SUM_W-1:0] MISS_MAX = {{(SUM_W-MISS_W){1'b0}}, {MISS_W{1'b1}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NUM_HOLES-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_HOLES-1:0]            active_q, active_d;
   logic [NUM_HOLES-1:0]            timeout_q, timeout_d;
   logic [NUM_HOLES-1:0]            hit_q, hit_d;
   logic [MISS_W-1:0]               miss_q, miss_d;
   logic                            run;
   logic [SUM_W-1:0]                expiries;
   logic [SUM_W-1:0]                miss_sum;

   // Lifetime in ticks for a given difficulty level.
   function automatic logic [CNT_W-1:0] level_ticks(input logic [1:0] lvl);
      logic [CNT_W-1:0] ticks;
      case (lvl)
         2'd0:    ticks = CNT_W'(TICKS_L0);
         2'd1:    ticks = CNT_W'(TICKS_L1);
         2'd2:    ticks = CNT_W'(TICKS_L2);
         default: ticks = CNT_W'(TICKS_L3);
      endcase
      return ticks;
   endfunction

   assign run = bus.enable & ~bus.pause;

   // Per-hole next state: disable clears, pause freezes, then start, hit,
   // expiry and plain countdown in falling priority. Pulses default to 0.
   always_comb begin
      cnt_d     = cnt_q;
      active_d  = active_q;
      timeout_d = '0;
      hit_d     = '0;
      for (int i = 0; i < NUM_HOLES; i++) begin
         if (!bus.enable) begin
            cnt_d[i]    = '0;
            active_d[i] = 1'b0;
         end else if (!bus.pause) begin
            if (bus.start[i]) begin
               cnt_d[i]    = level_ticks(bus.level);
               active_d[i] = 1'b1;
            end else if (bus.hit[i] && active_q[i]) begin
               cnt_d[i]    = '0;
               active_d[i] = 1'b0;
               hit_d[i]    = 1'b1;
            end else if (active_q[i] && (cnt_q[i] == CNT_ONE)) begin
               cnt_d[i]     = '0;
               active_d[i]  = 1'b0;
               timeout_d[i] = 1'b1;
            end else if (active_q[i]) begin
               cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
         end
      end
   end

   // Count the holes whose moles escape at this edge.
   always_comb begin
      expiries = '0;
      for (int i = 0; i < NUM_HOLES; i++) begin
         expiries = expiries + SUM_W'(timeout_d[i]);
      end
   end

   // Saturating miss total; a stats clear wins over a same-edge increment.
   always_comb begin
      miss_sum = SUM_W'(miss_q) + expiries;
      miss_d   = miss_q;
      if (bus.clear_stats) begin
         miss_d = '0;
      end else if (run) begin
         if (miss_sum > MISS_MAX) begin
            miss_d = MISS_W'(MISS_MAX);
         end else begin
            miss_d = MISS_W'(miss_sum);
         end
      end
   end

   // State and output registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk_game or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         active_q  <= '0;
         timeout_q <= '0;
         hit_q     <= '0;
         miss_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         timeout_q <= timeout_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
      end
   end

   assign bus.active        = active_q;
   assign bus.timeout_pulse = timeout_q;
   assign bus.hit_pulse     = hit_q;
   assign bus.miss_count    = miss_q;
   assign bus.any_active    = |active_q;

endmodule

// File: tb/tb_mole_timer_bank.sv
// Testbench for mole_timer_bank: directed scenarios for lifetimes, hits,
// restarts, pause, disable, saturation and async reset, followed by random
// traffic, all compared against a remaining-lifetime reference model.
module tb_mole_timer_bank;

   localparam int NH       = 4;
   localparam int CW       = 8;
   localparam int MW       = 3;
   localparam int MISS_MAX = (1 << MW) - 1;

   logic clk_game;
   logic rst;
   int   tests_run;
   int   tests_failed;

   mole_timer_bank_if #(.NUM_HOLES(NH), .MISS_W(MW)) bus ();

   mole_timer_bank #(
      .NUM_HOLES(NH),
      .CNT_W(CW),
      .MISS_W(MW),
      .TICKS_L0(10),
      .TICKS_L1(7),
      .TICKS_L2(4),
      .TICKS_L3(2)
   ) dut (
      .clk_game(clk_game),
      .rst(rst),
      .bus(bus)
   );

   // Reference model: ticks of life left per hole, plus last-edge pulses.
   int             mRem[NH];
   bit             mAct[NH];
   logic [NH-1:0]  mTo;
   logic [NH-1:0]  mHit;
   int             mMiss;

   // Free-running game tick clock.
   initial begin
      clk_game = 1'b0;
      forever #5 clk_game = ~clk_game;
   end

   function automatic int lifeOf(input logic [1:0] lvl);
      case (lvl)
         2'd0:    return 10;
         2'd1:    return 7;
         2'd2:    return 4;
         default: return 2;
      endcase
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NH; i++) begin
         mRem[i] = 0;
         mAct[i] = 0;
      end
      mTo   = '0;
      mHit  = '0;
      mMiss = 0;
   endtask

   // One game tick of the model, using the inputs present at the edge.
   task automatic modelStep();
      int escaped;
      escaped = 0;
      mTo     = '0;
      mHit    = '0;
      for (int i = 0; i < NH; i++) begin
         if (!bus.enable) begin
            mRem[i] = 0;
            mAct[i] = 0;
         end else if (bus.pause) begin
            mRem[i] = mRem[i];
         end else if (bus.start[i]) begin
            mRem[i] = lifeOf(bus.level);
            mAct[i] = 1;
         end else if (mAct[i] && bus.hit[i]) begin
            mRem[i] = 0;
            mAct[i] = 0;
            mHit[i] = 1'b1;
         end else if (mAct[i]) begin
            mRem[i] = mRem[i] - 1;
            if (mRem[i] == 0) begin
               mAct[i] = 0;
               mTo[i]  = 1'b1;
               escaped++;
            end
         end
      end
      if (bus.clear_stats) mMiss = 0;
      else if (bus.enable && !bus.pause) begin
         mMiss = mMiss + escaped;
         if (mMiss > MISS_MAX) mMiss = MISS_MAX;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic pse, input logic clr,
                                input logic [1:0] lvl, input logic [NH-1:0] st,
                                input logic [NH-1:0] ht);
      bus.enable      = en;
      bus.pause       = pse;
      bus.clear_stats = clr;
      bus.level       = lvl;
      bus.start       = st;
      bus.hit         = ht;
   endtask

   task automatic compareAll();
      logic [NH-1:0] actVec;
      for (int i = 0; i < NH; i++) actVec[i] = mAct[i];
      checkOutput("active", 32'(bus.active), 32'(actVec));
      checkOutput("timeout_pulse", 32'(bus.timeout_pulse), 32'(mTo));
      checkOutput("hit_pulse", 32'(bus.hit_pulse), 32'(mHit));
      checkOutput("any_active", 32'(bus.any_active), 32'(|actVec));
      checkOutput("miss_count", 32'(bus.miss_count), 32'(mMiss));
   endtask

   task automatic stepCycle();
      @(posedge clk_game);
      modelStep();
      #1;
      compareAll();
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, '0);
         stepCycle();
      end
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      int toEdge;
      int toCnt;
      int hitEdge;
      int actCnt;
      tests_run    = 0;
      tests_failed = 0;
      modelReset();
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, '0);
      #2;
      compareAll();
      #6;
      rst = 1'b0;

      // Lifetime at level 0 and level 3 on hole 0.
      for (int pass = 0; pass < 2; pass++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, (pass == 0) ? 2'd0 : 2'd3, 4'b0001, '0);
         stepCycle();
         actCnt = bus.active[0] ? 1 : 0;
         toCnt  = 0;
         toEdge = -1;
         for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, '0);
            stepCycle();
            if (bus.active[0]) actCnt++;
            if (bus.timeout_pulse[0]) begin
               toCnt++;
               toEdge = k;
            end
         end
         checkOutput("lifetime_active_cycles", 32'(actCnt), (pass == 0) ? 32'd10 : 32'd2);
         checkOutput("lifetime_timeout_edge", 32'(toEdge), (pass == 0) ? 32'd10 : 32'd2);
         checkOutput("lifetime_timeout_count", 32'(toCnt), 32'd1);
         checkOutput("lifetime_miss", 32'(bus.miss_count), 32'(pass + 1));
      end

      // Level 2 mole hit mid-life (E2) and on its expiry edge (E4).
      for (int pass = 0; pass < 2; pass++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 4'b0010, '0);
         stepCycle();
         toCnt   = 0;
         hitEdge = -1;
         for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, '0,
                          (k == ((pass == 0) ? 2 : 4)) ? 4'b0010 : 4'b0000);
            stepCycle();
            if (bus.hit_pulse[1]) hitEdge = k;
            if (bus.timeout_pulse[1]) toCnt++;
         end
         checkOutput("hit_edge", 32'(hitEdge), (pass == 0) ? 32'd2 : 32'd4);
         checkOutput("hit_no_timeout", 32'(toCnt), 32'd0);
         checkOutput("hit_miss_held", 32'(bus.miss_count), 32'd2);
      end

      // Restart with a new level latches the new lifetime.
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, '0);
      stepCycle();
      toCnt  = 0;
      toEdge = -1;
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, (k == 5) ? 4'b0100 : 4'b0000, '0);
         stepCycle();
         if (bus.timeout_pulse[2]) begin
            toCnt++;
            toEdge = k;
         end
      end
      checkOutput("restart_timeout_edge", 32'(toEdge), 32'd7);
      checkOutput("restart_timeout_count", 32'(toCnt), 32'd1);

      // Level 1 mole paused for three ticks expires three ticks late.
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, '0);
      stepCycle();
      toEdge = -1;
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b1, (k >= 2 && k <= 4), 1'b0, 2'd1, '0, '0);
         stepCycle();
         if (bus.timeout_pulse[3]) toEdge = k;
      end
      checkOutput("pause_timeout_edge", 32'(toEdge), 32'd10);

      // Dropping enable mid-life kills the mole silently.
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, '0);
      stepCycle();
      toCnt = 0;
      for (int k = 1; k <= 12; k++) begin
         applyStimulus((k < 3 || k > 5), 1'b0, 1'b0, 2'd0, '0, '0);
         stepCycle();
         if (bus.timeout_pulse[0]) toCnt++;
         if (k == 3) checkOutput("disable_active", 32'(bus.active[0]), 32'd0);
      end
      checkOutput("disable_no_timeout", 32'(toCnt), 32'd0);
      checkOutput("disable_miss_held", 32'(bus.miss_count), 32'd4);

      // Four simultaneous escapes saturate the counter; clear wins after.
      for (int pass = 0; pass < 2; pass++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 4'b1111, '0);
         stepCycle();
         for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, (pass == 1 && k == 4), 2'd2, '0, '0);
            stepCycle();
         end
         checkOutput("sat_timeouts", 32'(bus.timeout_pulse), 32'hF);
         checkOutput("sat_miss", 32'(bus.miss_count), (pass == 0) ? 32'(MISS_MAX) : 32'd0);
      end

      // Asynchronous reset between edges mid-countdown.
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'b0011, '0);
      stepCycle();
      idleCycles(2);
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("areset_active", 32'(bus.active), 32'd0);
      checkOutput("areset_any_active", 32'(bus.any_active), 32'd0);
      compareAll();
      #2;
      rst = 1'b0;
      toCnt = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, '0);
         stepCycle();
         if (bus.timeout_pulse != 0 || bus.hit_pulse != 0) toCnt++;
      end
      checkOutput("areset_no_pulses", 32'(toCnt), 32'd0);

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         logic [NH-1:0] st;
         logic [NH-1:0] ht;
         for (int i = 0; i < NH; i++) begin
            st[i] = ($urandom_range(0, 99) < 15);
            ht[i] = ($urandom_range(0, 99) < 20);
         end
         applyStimulus(($urandom_range(0, 99) < 95), ($urandom_range(0, 99) < 10),
                       ($urandom_range(0, 99) < 3), 2'($urandom_range(0, 3)), st, ht);
         stepCycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mole_timer_bank.md
# mole_timer_bank

Multi-hole mole lifetime timer bank for the whack-a-mole game core. Each of `NUM_HOLES` channels runs an independent countdown whose length is chosen from four difficulty levels at the moment its mole appears. A channel ends its timer either by expiry, which emits a timeout pulse, or by a valid hit, which emits a hit pulse. The block sits between the mole spawner, which supplies `start`, the button debouncer, which supplies `hit`, and the scoring/lives logic, which consumes the pulses and `miss_count`.

## Interface
- `NUM_HOLES`, 4: number of independent channels; range 1..16.
- `CNT_W`, 8: countdown width; must hold the largest `TICKS_Lx`.
- `MISS_W`, 8: width of the saturating miss counter.
- `TICKS_L0`, 10: lifetime in game ticks, level 0 (easy). All `TICKS_Lx` must be ≥1.
- `TICKS_L1`, 7: lifetime, level 1 (medium).
- `TICKS_L2`, 4: lifetime, level 2 (hard).
- `TICKS_L3`, 2: lifetime, level 3 (expert).

Ports:
- `clk_game`  in  1  game tick clock; every edge is one tick.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  game running. When low, all channels are cleared.
- `pause`  in  1  freezes all channels; `start` and `hit` are ignored.
- `clear_stats`  in  1  synchronous clear of `miss_count`.
- `level`  in  2  difficulty level, sampled per channel on `start`.
- `start`  in  NUM_HOLES  one-cycle pulse per channel; a new mole appears.
- `hit`  in  NUM_HOLES  debounced one-cycle hit pulse per channel.
- `active`  out  NUM_HOLES  mole present / timer running, per channel.
- `timeout_pulse`  out  NUM_HOLES  one-cycle pulse; channel expired unhit.
- `hit_pulse`  out  NUM_HOLES  one-cycle pulse; valid hit on an active channel.
- `any_active`  out  1  OR of `active`.
- `miss_count`  out  MISS_W  saturating total of timeouts.

## Operation
Each channel holds a `CNT_W` countdown `cnt[i]` and an `active[i]` flag. The internal term `run = enable & ~pause`.

Per-channel priority at each edge, highest first:
1. `~enable`: `cnt`←0, `active`←0, no pulses.
2. `pause`: everything holds and pulses are 0.
3. `start[i]`: `cnt`←TICKS_L[`level`] and `active`←1. If the channel was already active, it restarts with no pulse.
4. `hit[i]` & `active[i]`: `active`←0, `cnt`←0, `hit_pulse[i]`←1.
5. `active[i]` & `cnt==1`: `active`←0, `cnt`←0, `timeout_pulse[i]`←1.
6. `active[i]`: `cnt`←`cnt`−1.

Other rules:
- A hit on an inactive channel is ignored and produces no pulse.
- A hit and expiry at the same edge count as a hit, with no timeout.
- A change on `level` during a channel's life has no effect until that channel's next `start`.
- Channels are fully independent. Any combination of simultaneous starts, hits and timeouts is legal.
- `miss_count` updates at an edge where `run` is high: it gains the popcount of the channels timing out at that edge and saturates at 2^MISS_W−1.
- `clear_stats` sets `miss_count` to 0 and takes priority over a same-edge increment.
- `miss_count` is unaffected by `enable` and `pause`.

## Timing
- Reset values: `active`=0, `timeout_pulse`=0, `hit_pulse`=0, `cnt`=0, `miss_count`=0, `any_active`=0.
- All outputs are registered except `any_active`, which is combinational OR of the registered `active`.
- If `start` is sampled at edge E0 with level L, then `active` is 1 from just after E0 until edge E0+TICKS_L. At that edge `active` falls and `timeout_pulse` is high for exactly one cycle, provided there is no hit or pause.
- A hit sampled at edge E gives `hit_pulse` and a falling `active` just after E, i.e. 1-cycle latency.
- Every cycle in which `pause` is high extends the remaining lifetime by one cycle.
- Pulses are never asserted for more than one cycle, and never in the cycle after a reset release unless caused by inputs sampled at that edge.

## Test plan
- **Level lifetime.** Level=0, `start[0]` at E0, run=1. `active[0]`=1 for 10 cycles; `timeout_pulse[0]` is a single pulse after E10; `miss_count`=1. Repeat for level 3: pulse after E2.
- **Hit and boundary.** Level 2, start at E0, hit at E2: `hit_pulse` after E2 and no timeout. Repeat with the hit at E4, the expiry edge: `hit_pulse` only, `miss_count` unchanged.
- **Restart and level latch.** Level 0 start at E0. Change `level` to 3 at E1, then restart at E5. Timeout occurs after E7, not after E10, and there is exactly one pulse.
- **Pause and disable.** Pause for 3 cycles mid-life of a level-1 mole: timeout is delayed to E10. Drop `enable` mid-life: `active`→0 after the next edge, no pulse, `miss_count` held.
- **Multi-channel and saturation.** With MISS_W=2, all four channels start together at level 2. Four simultaneous timeouts after E4 give `miss_count`=3 (saturated). `clear_stats` at the same edge as a timeout gives `miss_count`=0.
- **Async reset.** Assert `rst` mid-countdown between edges. All outputs are 0 immediately, and no pulses follow the release.
